// File: rtl/csi2tx_p2b_ctrl.sv
// csi2tx_p2b_ctrl: pixel-to-byte converter sequencer for CSI-2 TX
// Registers sensor pixels, selects one converter by data type, and tracks line bytes and errors.
module csi2tx_p2b_ctrl #(
    parameter int PIX_W     = 24,
    parameter int WC_W      = 16,
    parameter int FLUSH_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       data_type,
    input  logic [WC_W-1:0]  word_count,
    input  logic             sensor_pixel_vld,
    input  logic [PIX_W-1:0] sensor_pixel_data,
    output logic [PIX_W-1:0] pixel_data,
    output logic [PIX_W-1:0] pixel_data_d1,
    output logic             pixel_data_vld,
    output logic [1:0]       pixel_cnt,
    output logic             sensor_pixel_vld_falling_edge,
    output logic             rgb888_convrn_enable,
    output logic             rgb565_convrn_enable,
    output logic             raw8_convrn_enable,
    input  logic [31:0]      rgb888_dw,
    input  logic [31:0]      rgb565_dw,
    input  logic [31:0]      raw8_dw,
    input  logic             rgb888_dw_vld,
    input  logic             rgb565_dw_vld,
    input  logic             raw8_dw_vld,
    output logic [31:0]      dw,
    output logic             dw_vld,
    output logic [WC_W:0]    byte_cnt,
    output logic             line_done,
    output logic             wc_err,
    output logic             unsup_dt_err,
    output logic             ovr_err
);
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam logic [FW-1:0] FLAST = FW'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t        r_state;
    logic [5:0]    r_dt;
    logic [FW-1:0] r_fcnt;
    logic          w_888, w_565, w_raw8, w_start;
    logic [1:0]    w_bpp, w_pc_inc;
    logic [WC_W+1:0] w_sum;

    assign w_888  = r_dt == 6'h24;
    assign w_565  = r_dt == 6'h22;
    assign w_raw8 = r_dt == 6'h2A;
    assign rgb888_convrn_enable = w_888;
    assign rgb565_convrn_enable = w_565;
    assign raw8_convrn_enable   = w_raw8;

    assign w_bpp    = w_888 ? 2'd3 : w_565 ? 2'd2 : w_raw8 ? 2'd1 : 2'd0;
    assign w_pc_inc = w_565 ? {1'b0, ~pixel_cnt[0]} : pixel_cnt + 2'd1;
    assign w_sum    = {1'b0, byte_cnt} + (WC_W+2)'(w_bpp);
    assign w_start  = pixel_data_vld & (r_state != ACTIVE);

    assign dw     = w_888 ? rgb888_dw : w_565 ? rgb565_dw : w_raw8 ? raw8_dw : 32'd0;
    assign dw_vld = (r_state != IDLE) &
                    (w_888 ? rgb888_dw_vld : w_565 ? rgb565_dw_vld : w_raw8 & raw8_dw_vld);

    // A pixel arriving in FLUSH closes the old line early and opens the next one.
    assign line_done    = (r_state == FLUSH) & (pixel_data_vld | (r_fcnt == FLAST));
    assign wc_err       = line_done & (byte_cnt != {1'b0, word_count});
    assign unsup_dt_err = (r_state == IDLE) & pixel_data_vld & ~(w_888 | w_565 | w_raw8);
    assign ovr_err      = (r_state == FLUSH) & pixel_data_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state                       <= IDLE;
            r_dt                          <= '0;
            r_fcnt                        <= '0;
            pixel_data                    <= '0;
            pixel_data_d1                 <= '0;
            pixel_data_vld                <= 1'b0;
            pixel_cnt                     <= '0;
            sensor_pixel_vld_falling_edge <= 1'b0;
            byte_cnt                      <= '0;
        end else begin
            pixel_data                    <= sensor_pixel_data;
            pixel_data_vld                <= sensor_pixel_vld;
            sensor_pixel_vld_falling_edge <= pixel_data_vld & ~sensor_pixel_vld;
            if (pixel_data_vld)
                pixel_data_d1 <= pixel_data;
            if (r_state == IDLE)
                r_dt <= data_type;
            // pixel_cnt survives the line-end pulse, then clears so a restart begins at index 0
            if (pixel_data_vld)
                pixel_cnt <= w_pc_inc;
            else if (r_state != ACTIVE || sensor_pixel_vld_falling_edge)
                pixel_cnt <= '0;
            if (w_start)
                byte_cnt <= (WC_W+1)'(w_bpp);
            else if (pixel_data_vld)
                byte_cnt <= w_sum[WC_W+1] ? '1 : w_sum[WC_W:0];
            case (r_state)
                IDLE: if (pixel_data_vld) r_state <= ACTIVE;
                ACTIVE: if (sensor_pixel_vld_falling_edge) begin
                    r_state <= FLUSH;
                    r_fcnt  <= '0;
                end
                FLUSH: begin
                    if (pixel_data_vld)
                        r_state <= ACTIVE;
                    else if (r_fcnt == FLAST)
                        r_state <= IDLE;
                    r_fcnt <= r_fcnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csi2tx_p2b_ctrl.sv
// tb_csi2tx_p2b_ctrl: directed self-checking bench for csi2tx_p2b_ctrl
// Converter word valids are held high so dw_vld directly reflects the state gating.
module tb_csi2tx_p2b_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [5:0]  data_type = '0;
    logic [15:0] word_count = '0;
    logic        sensor_pixel_vld = 0;
    logic [23:0] sensor_pixel_data = '0;
    logic [23:0] pixel_data, pixel_data_d1;
    logic        pixel_data_vld, sensor_pixel_vld_falling_edge;
    logic [1:0]  pixel_cnt;
    logic        rgb888_convrn_enable, rgb565_convrn_enable, raw8_convrn_enable;
    logic [31:0] rgb888_dw = 32'h8888_8888, rgb565_dw = 32'h5656_5656, raw8_dw = 32'h0808_0808;
    logic        rgb888_dw_vld = 1, rgb565_dw_vld = 1, raw8_dw_vld = 1;
    logic [31:0] dw;
    logic        dw_vld;
    logic [16:0] byte_cnt;
    logic        line_done, wc_err, unsup_dt_err, ovr_err;
    int checks = 0, errors = 0;

    csi2tx_p2b_ctrl dut (
        .clk(clk), .rst_n(rst_n), .data_type(data_type), .word_count(word_count),
        .sensor_pixel_vld(sensor_pixel_vld), .sensor_pixel_data(sensor_pixel_data),
        .pixel_data(pixel_data), .pixel_data_d1(pixel_data_d1), .pixel_data_vld(pixel_data_vld),
        .pixel_cnt(pixel_cnt), .sensor_pixel_vld_falling_edge(sensor_pixel_vld_falling_edge),
        .rgb888_convrn_enable(rgb888_convrn_enable), .rgb565_convrn_enable(rgb565_convrn_enable),
        .raw8_convrn_enable(raw8_convrn_enable),
        .rgb888_dw(rgb888_dw), .rgb565_dw(rgb565_dw), .raw8_dw(raw8_dw),
        .rgb888_dw_vld(rgb888_dw_vld), .rgb565_dw_vld(rgb565_dw_vld), .raw8_dw_vld(raw8_dw_vld),
        .dw(dw), .dw_vld(dw_vld), .byte_cnt(byte_cnt), .line_done(line_done), .wc_err(wc_err),
        .unsup_dt_err(unsup_dt_err), .ovr_err(ovr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pix"}, {pixel_data, pixel_data_d1, pixel_data_vld, pixel_cnt}, 0);
        chk({tag, "_ctl"}, {sensor_pixel_vld_falling_edge, rgb888_convrn_enable,
            rgb565_convrn_enable, raw8_convrn_enable, dw_vld, line_done, wc_err,
            unsup_dt_err, ovr_err}, 0);
        chk({tag, "_dw"}, dw, 0);
        chk({tag, "_bc"}, byte_cnt, 0);
    endtask

    // One full line: n pixels, then the line-end pulse and the FLUSH window.
    task automatic run_line(input logic [5:0] dt, input logic [15:0] wc, input int n,
                            input int bpp, input int m, input logic [2:0] en,
                            input logic [31:0] exp_dw, input logic werr, input logic [23:0] base);
        data_type = dt;
        word_count = wc;
        tick();
        chk("enables", {rgb888_convrn_enable, rgb565_convrn_enable, raw8_convrn_enable}, en);
        chk("dw_sel", dw, exp_dw);
        chk("dw_vld_idle", dw_vld, 0);
        for (int i = 0; i < n; i++) begin
            sensor_pixel_vld = 1;
            sensor_pixel_data = base + 24'(i);
            tick();
            chk("pix_vld", pixel_data_vld, 1);
            chk("pix_data", pixel_data, base + 24'(i));
            chk("pix_cnt", pixel_cnt, i % m);
            chk("dw_vld_line", dw_vld, (en != 0) && (i > 0));
            if (i == 0) chk("unsup", unsup_dt_err, en == 0);
            else begin
                chk("pix_d1", pixel_data_d1, base + 24'(i - 1));
                chk("byte_cnt_run", byte_cnt, bpp * i);
            end
        end
        sensor_pixel_vld = 0;
        tick();
        chk("fe", sensor_pixel_vld_falling_edge, 1);
        chk("pix_cnt_hold", pixel_cnt, n % m);
        chk("byte_cnt_end", byte_cnt, bpp * n);
        chk("done_early0", line_done, 0);
        chk("dw_vld_fe", dw_vld, en != 0);
        tick();
        chk("fe_clear", sensor_pixel_vld_falling_edge, 0);
        chk("done_early1", line_done, 0);
        tick();
        chk("line_done", line_done, 1);
        chk("wc_err", wc_err, werr);
        chk("ovr_none", ovr_err, 0);
        tick();
        chk("done_clear", line_done, 0);
        chk("dw_vld_after", dw_vld, 0);
        chk("byte_cnt_hold", byte_cnt, bpp * n);
    endtask

    initial begin
        #2;
        chk_zero("reset");
        tick();
        tick();
        rst_n = 1;
        tick();
        chk_zero("post_reset");

        run_line(6'h24, 16'd12, 4, 3, 4, 3'b100, 32'h8888_8888, 0, 24'h100000);
        run_line(6'h24, 16'd15, 5, 3, 4, 3'b100, 32'h8888_8888, 0, 24'h200000);
        run_line(6'h22, 16'd10, 4, 2, 2, 3'b010, 32'h5656_5656, 1, 24'h300000);
        run_line(6'h2B, 16'd0, 3, 0, 4, 3'b000, 32'h0, 0, 24'h400000);

        // RAW8 line, then a new line starts inside FLUSH
        data_type = 6'h2A;
        word_count = 16'd3;
        tick();
        chk("raw8_en", raw8_convrn_enable, 1);
        for (int i = 0; i < 3; i++) begin
            sensor_pixel_vld = 1;
            sensor_pixel_data = 24'h50 + 24'(i);
            tick();
        end
        sensor_pixel_vld = 0;
        tick();
        chk("ovr_fe", sensor_pixel_vld_falling_edge, 1);
        chk("ovr_bc_first", byte_cnt, 3);
        sensor_pixel_vld = 1;
        tick();
        chk("ovr_err", ovr_err, 1);
        chk("ovr_done", line_done, 1);
        chk("ovr_wc_ok", wc_err, 0);
        chk("ovr_pc0", pixel_cnt, 0);
        tick();
        chk("ovr_err_clr", ovr_err, 0);
        chk("ovr_done_clr", line_done, 0);
        chk("ovr_restart_bc", byte_cnt, 1);
        chk("ovr_pc1", pixel_cnt, 1);
        sensor_pixel_vld = 0;
        tick();
        chk("ovr_fe2", sensor_pixel_vld_falling_edge, 1);
        chk("ovr_bc2", byte_cnt, 2);
        tick();
        chk("ovr_no_done", line_done, 0);
        tick();
        chk("ovr_done2", line_done, 1);
        chk("ovr_wc_err2", wc_err, 1);
        tick();

        // Reset in the middle of an RGB888 line
        data_type = 6'h24;
        word_count = 16'd12;
        tick();
        for (int i = 0; i < 2; i++) begin
            sensor_pixel_vld = 1;
            sensor_pixel_data = 24'h600000 + 24'(i);
            tick();
        end
        chk("pre_rst_bc", byte_cnt, 3);
        rst_n = 0;
        #1;
        chk_zero("mid_reset");
        sensor_pixel_vld = 0;
        tick();
        chk_zero("mid_reset_hold");
        rst_n = 1;
        tick();
        chk("no_done_after_rst", line_done, 0);
        run_line(6'h24, 16'd12, 4, 3, 4, 3'b100, 32'h8888_8888, 0, 24'h700000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/csi2tx_p2b_ctrl.md
Name: csi2tx_p2b_ctrl

Overview:
- Sequencer for the CSI-2 TX pixel-to-byte converters (RGB888, RGB565, RAW8); sits between the sensor pixel interface and the converter bank.
- Registers the sensor pixel stream and generates the per-format pixel count, delayed pixel and line-end pulse the converters need.
- Decodes the data type into a single converter enable and muxes the selected converter's 32-bit word output.
- Tracks bytes per line against the programmed word count and signals line completion and errors to the packet builder.

Parameters:
- PIX_W, 24, sensor pixel bus width
- WC_W, 16, word-count width (bytes per line)
- FLUSH_CYC, 2, cycles held in FLUSH after line end, covering converter output latency

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_type  in  6  CSI-2 data type; quasi-static, stable from 1 cycle before line start to line_done
- word_count  in  WC_W  expected payload bytes per line
- sensor_pixel_vld  in  1  sensor pixel valid; high for the whole line
- sensor_pixel_data  in  PIX_W  sensor pixel
- pixel_data  out  PIX_W  registered pixel to converters
- pixel_data_d1  out  PIX_W  previous valid pixel
- pixel_data_vld  out  1  registered valid
- pixel_cnt  out  2  pixel index within word group
- sensor_pixel_vld_falling_edge  out  1  1-cycle line-end pulse
- rgb888_convrn_enable  out  1  converter enable
- rgb565_convrn_enable  out  1  converter enable
- raw8_convrn_enable  out  1  converter enable
- rgb888_dw / rgb565_dw / raw8_dw  in  32 each  converter words
- rgb888_dw_vld / rgb565_dw_vld / raw8_dw_vld  in  1 each  converter word valids
- dw  out  32  muxed word
- dw_vld  out  1  muxed word valid
- byte_cnt  out  WC_W+1  bytes accumulated in current/last line
- line_done  out  1  1-cycle pulse at line completion
- wc_err  out  1  1-cycle pulse with line_done when byte_cnt != word_count
- unsup_dt_err  out  1  1-cycle pulse at line start for unsupported data type
- ovr_err  out  1  1-cycle pulse when a new line starts during FLUSH

Behaviour:
- Reset: all outputs 0; state IDLE; internal registers 0.
- Registered-domain conversion:
  - pixel_data, pixel_data_vld = sensor inputs delayed 1 cycle.
  - pixel_data_d1 loads pixel_data on each pixel_data_vld.
  - sensor_pixel_vld_falling_edge = pixel_data_vld(prev) & ~pixel_data_vld.
- Data-type decode:
  - dt_q loads data_type every cycle in IDLE and is frozen otherwise.
  - Decode map: 6'h24 -> rgb888_convrn_enable; 6'h22 -> rgb565_convrn_enable; 6'h2A -> raw8_convrn_enable; any other code -> no enable.
  - At most one enable is high at any time.
- pixel_cnt:
  - Cleared in IDLE.
  - Increments after each pixel_data_vld: modulo 4 for RGB888/RAW8, modulo 2 for RGB565 (bit1 = 0).
  - Value presented alongside a pixel is that pixel's index.
  - Holds its value through the line-end pulse so converters can detect a partial final word.
- Bytes per pixel (bpp): RGB888 = 3, RGB565 = 2, RAW8 = 1, unsupported = 0.
- byte_cnt: cleared on line start; adds bpp per pixel_data_vld; saturates at all-ones; holds after line_done until the next line starts.
- dw/dw_vld: dw = selected converter dw; dw_vld = selected dw_vld gated by state ACTIVE or FLUSH. When no converter is selected, dw = 0 and dw_vld = 0.
- FSM:
  - IDLE -> ACTIVE on pixel_data_vld. unsup_dt_err pulses this cycle if no enable is decoded.
  - ACTIVE -> FLUSH on sensor_pixel_vld_falling_edge. A valid drop mid-line is, by definition, a line end.
  - FLUSH counts FLUSH_CYC cycles, then -> IDLE. line_done pulses on the exit cycle; wc_err pulses the same cycle if byte_cnt != word_count.
  - If pixel_data_vld is seen in FLUSH: ovr_err and line_done (plus wc_err if mismatched) pulse that cycle, byte_cnt and pixel_cnt restart with that pixel, and state -> ACTIVE. dt_q is not reloaded.
- Reset mid-line: immediate return to IDLE, all outputs 0, no line_done.

Test Plan:
- RGB888 (0x24), word_count = 12, 4 pixels -> pixel_cnt 0,1,2,3; 3 dw_vld pulses; byte_cnt = 12; line_done at 2 cycles after the line-end pulse; wc_err = 0.
- RGB888, word_count = 15, 5 pixels -> pixel_cnt = 1 held during the line-end pulse; 4 dw_vld pulses; byte_cnt = 15; no wc_err.
- RGB565 (0x22), 4 pixels, word_count = 10 -> pixel_cnt 0,1,0,1; byte_cnt = 8; wc_err pulses together with line_done.
- data_type = 0x2B, 3 pixels -> unsup_dt_err pulses at line start; no enables; dw_vld never asserts; byte_cnt = 0.
- RAW8 line, sensor valid re-asserted 1 cycle after the line-end pulse -> ovr_err and line_done pulse; new line counts from byte_cnt = 1.
- rst_n asserted mid-line on a RGB888 line -> all outputs 0 asynchronously; next line behaves as in the first scenario.
